// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// address-segment and fault-instruction constants, reset polarity.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IF_REQ   = 2'd0,
        IF_WAIT  = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_t;

    localparam logic [2:0]  UNCACHED_SEG_DEF = 3'b101;
    localparam logic [31:0] NOP_INST_DEF     = 32'h0000_0000;
    localparam logic        RESET_ACTIVE     = 1'b0;

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry skid register that parks a fetched instruction while decode
// is stalled.
module inst_hold_buf
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       inst_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              adel_in,
    output logic              valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    output logic              adel
);

    logic              valid_reg;
    logic [31:0]       inst_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              adel_reg;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (reset_i == RESET_ACTIVE) begin
            valid_reg <= 1'b0;
            inst_reg  <= '0;
            pc_reg    <= '0;
            adel_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            inst_reg  <= inst_in;
            pc_reg    <= pc_in;
            adel_reg  <= adel_in;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign inst  = inst_reg;
    assign pc    = pc_reg;
    assign adel  = adel_reg;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: issues one SRAM-like read at a time, stalls
// the PC while it is outstanding, buffers under decode stall, drops on flush.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [2:0]  UNCACHED_SEG = UNCACHED_SEG_DEF,
    parameter logic [31:0] NOP_INST     = NOP_INST_DEF
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              pipe_stall_i,
    output logic              fetch_stall_o,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_uncached_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [31:0]       inst_rdata_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_adel_o
);

    if_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] req_pc_reg;
    logic              inst_valid_reg;
    logic [31:0]       inst_reg;
    logic [ADDR_W-1:0] inst_pc_reg;
    logic              inst_adel_reg;

    logic              misaligned;
    logic              capture_pc;
    logic              deliver;
    logic [31:0]       cand_inst;
    logic [ADDR_W-1:0] cand_pc;
    logic              cand_adel;
    logic              buf_load;
    logic              buf_clear;
    logic              buf_valid;
    logic [31:0]       buf_inst;
    logic [ADDR_W-1:0] buf_pc;
    logic              buf_adel;

    assign misaligned = (pc_i[1:0] != 2'b00);

    inst_hold_buf #(
        .ADDR_W(ADDR_W)
    ) u_hold_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .load    (buf_load),
        .clear   (buf_clear),
        .inst_in (cand_inst),
        .pc_in   (cand_pc),
        .adel_in (cand_adel),
        .valid   (buf_valid),
        .inst    (buf_inst),
        .pc      (buf_pc),
        .adel    (buf_adel)
    );

    // cand_* is whatever instruction is on offer this cycle; it either
    // goes to decode (deliver) or into the hold buffer (buf_load).
    always_comb begin
        state_next = state_reg;
        capture_pc = 1'b0;
        deliver    = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        cand_inst  = inst_rdata_i;
        cand_pc    = req_pc_reg;
        cand_adel  = 1'b0;

        case (state_reg)
            IF_REQ: begin
                if (misaligned) begin
                    cand_inst = NOP_INST;
                    cand_pc   = pc_i;
                    cand_adel = 1'b1;
                    if (!flush_i) begin
                        if (pipe_stall_i) begin
                            buf_load   = 1'b1;
                            state_next = IF_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (inst_addr_ok_i) begin
                    capture_pc = 1'b1;
                    state_next = flush_i ? IF_DRAIN : IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (inst_data_ok_i) begin
                    if (flush_i) begin
                        state_next = IF_REQ;
                    end else if (pipe_stall_i) begin
                        buf_load   = 1'b1;
                        state_next = IF_HOLD;
                    end else begin
                        deliver    = 1'b1;
                        state_next = IF_REQ;
                    end
                end else if (flush_i) begin
                    state_next = IF_DRAIN;
                end
            end
            IF_HOLD: begin
                cand_inst = buf_inst;
                cand_pc   = buf_pc;
                cand_adel = buf_adel;
                if (flush_i) begin
                    buf_clear  = 1'b1;
                    state_next = IF_REQ;
                end else if (!pipe_stall_i && buf_valid) begin
                    deliver    = 1'b1;
                    buf_clear  = 1'b1;
                    state_next = IF_REQ;
                end
            end
            IF_DRAIN: begin
                if (inst_data_ok_i) begin
                    state_next = IF_REQ;
                end
            end
            default: state_next = IF_REQ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (reset_i == RESET_ACTIVE) begin
            state_reg      <= IF_REQ;
            req_pc_reg     <= '0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
            inst_adel_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            inst_valid_reg <= deliver;
            if (capture_pc) begin
                req_pc_reg <= pc_i;
            end
            if (deliver) begin
                inst_reg      <= cand_inst;
                inst_pc_reg   <= cand_pc;
                inst_adel_reg <= cand_adel;
            end
        end
    end

    assign inst_req_o      = (state_reg == IF_REQ) && !misaligned;
    assign inst_addr_o     = (state_reg == IF_REQ) ? pc_i : req_pc_reg;
    assign inst_uncached_o = inst_req_o && (inst_addr_o[ADDR_W-1 -: 3] == UNCACHED_SEG);
    // Releasing the PC on flush lets it load the redirect target right away.
    assign fetch_stall_o   = !(deliver || flush_i);

    assign inst_valid_o = inst_valid_reg;
    assign inst_o       = inst_reg;
    assign inst_pc_o    = inst_pc_reg;
    assign inst_adel_o  = inst_adel_reg;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scenario bench for inst_fetch_ctrl; a negedge monitor pops expected
// deliveries from a queue filled as each delivering stimulus is driven.
module tb_inst_fetch_ctrl;

    logic        clock_i;
    logic        reset_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        pipe_stall_i;
    logic        fetch_stall_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_uncached_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_adel_o;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    inst_fetch_ctrl dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .pc_i            (pc_i),
        .flush_i         (flush_i),
        .pipe_stall_i    (pipe_stall_i),
        .fetch_stall_o   (fetch_stall_o),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_uncached_o (inst_uncached_o),
        .inst_addr_ok_i  (inst_addr_ok_i),
        .inst_data_ok_i  (inst_data_ok_i),
        .inst_rdata_i    (inst_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_adel_o     (inst_adel_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    always @(negedge clock_i) begin
        if (reset_i && inst_valid_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: got inst=%h pc=%h adel=%b, required no pulse",
                         inst_o, inst_pc_o, inst_adel_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({inst_o, inst_pc_o, inst_adel_o} !== mon_e) begin
                    miscompares++;
                    $display("FAIL delivery: got inst=%h pc=%h adel=%b, required inst=%h pc=%h adel=%b",
                             inst_o, inst_pc_o, inst_adel_o, mon_e.inst, mon_e.pc, mon_e.adel);
                end else begin
                    $display("deliver inst=%h pc=%h adel=%b", inst_o, inst_pc_o, inst_adel_o);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; pc_i = 32'hbfc0_0000; flush_i = 0; pipe_stall_i = 0;
        inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = 32'h0;
        repeat (2) @(negedge clock_i);
        vectors++;
        if ({inst_valid_o, inst_o, inst_pc_o, inst_adel_o} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h adel=%b, required all 0",
                     inst_valid_o, inst_o, inst_pc_o, inst_adel_o);
        end
        vectors++;
        if (fetch_stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall: got %b required 1", fetch_stall_o);
        end
        next_cycle();
        reset_i = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic_fetch();
        inst_addr_ok_i = 1;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, inst_uncached_o, fetch_stall_o} !== 3'b111) begin
            miscompares++;
            $display("FAIL basic_c1: got req=%b unc=%b stall=%b, required 1 1 1",
                     inst_req_o, inst_uncached_o, fetch_stall_o);
        end
        next_cycle();
        inst_addr_ok_i = 0;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, inst_uncached_o, fetch_stall_o, inst_addr_o} !== {3'b001, 32'hbfc0_0000}) begin
            miscompares++;
            $display("FAIL basic_c2: got req=%b unc=%b stall=%b addr=%h, required 0 0 1 bfc00000",
                     inst_req_o, inst_uncached_o, fetch_stall_o, inst_addr_o);
        end
        next_cycle();
        inst_data_ok_i = 1; inst_rdata_i = 32'h2408_0001;
        exp_q.push_back('{inst: 32'h2408_0001, pc: 32'hbfc0_0000, adel: 1'b0});
        @(negedge clock_i);
        vectors++;
        if (fetch_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_c3_stall: got %b required 0", fetch_stall_o);
        end
        next_cycle();
        inst_data_ok_i = 0; pc_i = 32'h0040_0000;
        @(negedge clock_i);
        vectors++;
        if ({inst_valid_o, fetch_stall_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL basic_c4: got valid=%b stall=%b, required 1 1", inst_valid_o, fetch_stall_o);
        end
        $display("basic fetch done");
    endtask

    task automatic test_decode_stall();
        next_cycle();
        inst_addr_ok_i = 1;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, inst_uncached_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_req: got req=%b unc=%b, required 1 0", inst_req_o, inst_uncached_o);
        end
        next_cycle();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h8c42_0010; pipe_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            vectors++;
            if ({fetch_stall_o, inst_valid_o} !== 2'b10) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got stall=%b valid=%b, required 1 0", i, fetch_stall_o, inst_valid_o);
            end
            next_cycle();
            inst_data_ok_i = 0; inst_rdata_i = 32'hffff_ffff;
        end
        pipe_stall_i = 0;
        exp_q.push_back('{inst: 32'h8c42_0010, pc: 32'h0040_0000, adel: 1'b0});
        @(negedge clock_i);
        vectors++;
        if (fetch_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: got %b required 0", fetch_stall_o);
        end
        next_cycle();
        pc_i = 32'h0040_0004;
        $display("decode stall done");
    endtask

    task automatic test_flush_wait();
        inst_addr_ok_i = 1;
        next_cycle();
        inst_addr_ok_i = 0; flush_i = 1; pc_i = 32'h8000_0180;
        @(negedge clock_i);
        vectors++;
        if ({fetch_stall_o, inst_req_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL flushw_c1: got stall=%b req=%b, required 0 0", fetch_stall_o, inst_req_o);
        end
        next_cycle();
        flush_i = 0;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, fetch_stall_o, inst_addr_o} !== {2'b01, 32'h0040_0004}) begin
            miscompares++;
            $display("FAIL flushw_drain: got req=%b stall=%b addr=%h, required 0 1 00400004",
                     inst_req_o, fetch_stall_o, inst_addr_o);
        end
        next_cycle();
        inst_data_ok_i = 1; inst_rdata_i = 32'hdead_0001;
        @(negedge clock_i);
        vectors++;
        if (inst_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flushw_drop_req: got %b required 0", inst_req_o);
        end
        next_cycle();
        inst_data_ok_i = 0;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, inst_uncached_o, inst_addr_o} !== {2'b10, 32'h8000_0180}) begin
            miscompares++;
            $display("FAIL flushw_newreq: got req=%b unc=%b addr=%h, required 1 0 80000180",
                     inst_req_o, inst_uncached_o, inst_addr_o);
        end
        inst_addr_ok_i = 1;
        next_cycle();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h0000_0008;
        exp_q.push_back('{inst: 32'h0000_0008, pc: 32'h8000_0180, adel: 1'b0});
        next_cycle();
        inst_data_ok_i = 0; pc_i = 32'h0040_0008;
        $display("flush in wait done");
    endtask

    task automatic test_flush_coincident();
        inst_addr_ok_i = 1;
        next_cycle();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'hdead_0002; flush_i = 1;
        @(negedge clock_i);
        vectors++;
        if (fetch_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flushc_stall: got %b required 0", fetch_stall_o);
        end
        next_cycle();
        inst_data_ok_i = 0; flush_i = 0;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, inst_valid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL flushc_req: got req=%b valid=%b, required 1 0", inst_req_o, inst_valid_o);
        end
        inst_addr_ok_i = 1;
        next_cycle();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'hdead_0003; pipe_stall_i = 1;
        next_cycle();
        inst_data_ok_i = 0;
        @(negedge clock_i);
        vectors++;
        if ({fetch_stall_o, inst_req_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL flushh_hold: got stall=%b req=%b, required 1 0", fetch_stall_o, inst_req_o);
        end
        next_cycle();
        pipe_stall_i = 0; flush_i = 1;
        @(negedge clock_i);
        vectors++;
        if (fetch_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flushh_stall: got %b required 0", fetch_stall_o);
        end
        next_cycle();
        flush_i = 0;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, inst_valid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL flushh_req: got req=%b valid=%b, required 1 0", inst_req_o, inst_valid_o);
        end
        next_cycle();
        $display("flush coincident/hold done");
    endtask

    task automatic test_misaligned();
        pc_i = 32'hbfc0_0002;
        inst_addr_ok_i = 1;
        exp_q.push_back('{inst: 32'h0000_0000, pc: 32'hbfc0_0002, adel: 1'b1});
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, inst_uncached_o, fetch_stall_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL misal_c1: got req=%b unc=%b stall=%b, required 0 0 0",
                     inst_req_o, inst_uncached_o, fetch_stall_o);
        end
        next_cycle();
        inst_addr_ok_i = 0; pc_i = 32'hbfc0_0006; pipe_stall_i = 1;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, fetch_stall_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL misal_stall: got req=%b stall=%b, required 0 1", inst_req_o, fetch_stall_o);
        end
        next_cycle();
        pc_i = 32'h0040_0010; pipe_stall_i = 0;
        exp_q.push_back('{inst: 32'h0000_0000, pc: 32'hbfc0_0006, adel: 1'b1});
        @(negedge clock_i);
        vectors++;
        if (fetch_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL misal_release: got %b required 0", fetch_stall_o);
        end
        next_cycle();
        $display("misaligned done");
    endtask

    task automatic test_async_reset();
        inst_addr_ok_i = 1;
        next_cycle();
        inst_addr_ok_i = 0; pc_i = 32'h0040_0020;
        @(negedge clock_i);
        #2;
        reset_i = 1'b0;
        #1;
        vectors++;
        if ({inst_valid_o, inst_pc_o, inst_adel_o} !== 34'h0) begin
            miscompares++;
            $display("FAIL areset_clear: got valid=%b pc=%h adel=%b, required 0 0 0",
                     inst_valid_o, inst_pc_o, inst_adel_o);
        end
        vectors++;
        if ({inst_req_o, inst_addr_o} !== {1'b1, 32'h0040_0020}) begin
            miscompares++;
            $display("FAIL areset_state: got req=%b addr=%h, required 1 00400020", inst_req_o, inst_addr_o);
        end
        next_cycle();
        reset_i = 1'b1; inst_data_ok_i = 1; inst_rdata_i = 32'hdead_0004;
        @(negedge clock_i);
        vectors++;
        if ({inst_req_o, fetch_stall_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL areset_late: got req=%b stall=%b, required 1 1", inst_req_o, fetch_stall_o);
        end
        next_cycle();
        inst_data_ok_i = 0;
        repeat (3) next_cycle();
        $display("async reset done");
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_decode_stall();
        test_flush_wait();
        test_flush_coincident();
        test_misaligned();
        test_async_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_delivery: got %0d undelivered, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences instruction fetch between the PC register and an SRAM-like instruction bus (req / addr_ok / data_ok).
- Holds the PC via a stall output while a fetch is outstanding.
- Buffers a returned instruction while decode is stalled.
- Discards in-flight responses after a branch or exception flush, and delivers one instruction per completed fetch to the IF/ID stage.

Parameters:
- ADDR_W, 32, fetch address / PC width
- UNCACHED_SEG, 3'b101, PC[31:29] value marking the uncached kseg1 region
- NOP_INST, 32'h0000_0000, instruction word delivered for a faulting (misaligned) fetch

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  reset; asynchronous, active-low
- pc_i  in  ADDR_W  current PC from the PC register
- flush_i  in  1  branch redirect or exception; kills the current fetch
- pipe_stall_i  in  1  decode cannot accept an instruction this cycle
- fetch_stall_o  out  1  hold the PC (1 = hold)
- inst_req_o  out  1  bus request
- inst_addr_o  out  ADDR_W  bus address
- inst_uncached_o  out  1  (inst_addr_o[31:29]==UNCACHED_SEG) when inst_req_o is high, else 0
- inst_addr_ok_i  in  1  bus accepted the address
- inst_data_ok_i  in  1  read data valid
- inst_rdata_i  in  32  read data
- inst_valid_o  out  1  one-cycle pulse: inst_o / inst_pc_o are new
- inst_o  out  32  fetched instruction
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_adel_o  out  1  address-error flag for inst_o (misaligned PC)

Behaviour:
- Reset (reset_i=0, async): state=REQ; all registered outputs 0 (inst_valid_o, inst_o, inst_pc_o, inst_adel_o); captured req_pc=0; hold buffer empty.
- Only one bus transaction outstanding at a time.
- Combinational outputs:
  - inst_req_o=1 only in REQ with pc_i[1:0]==0.
  - inst_addr_o=pc_i in REQ, else req_pc.
- fetch_stall_o=0 only in a delivery cycle or when flush_i=1, so the PC takes its redirect target; otherwise 1.
- A delivery cycle is one in which an instruction is handed to decode with pipe_stall_i=0 and flush_i=0.
  - Registered outputs are written on the next clock edge: inst_valid_o=1 for exactly one cycle, plus inst_o, inst_pc_o and inst_adel_o.
  - Latency from inst_data_ok_i to inst_valid_o is 1 cycle.
- States:
  - REQ:
    - If pc_i[1:0]!=0: no bus request. Treated as data returned this cycle with NOP_INST and adel=1 (deliver or go to HOLD per pipe_stall_i).
    - On addr_ok: capture req_pc=pc_i, go to WAIT.
    - flush_i without addr_ok: stay in REQ; the address follows the new pc_i next cycle.
    - flush_i with addr_ok in the same cycle: go to DRAIN.
  - WAIT:
    - data_ok & flush_i: discard the data, go to REQ.
    - data_ok & pipe_stall_i: load the hold buffer, go to HOLD.
    - data_ok otherwise: deliver, go to REQ.
    - flush_i without data_ok: go to DRAIN.
  - HOLD:
    - pipe_stall_i=0: deliver the buffer, go to REQ.
    - flush_i: clear the buffer, go to REQ (flush beats delivery).
  - DRAIN: inst_req_o=0. On data_ok: drop it, go to REQ. Further flush_i stays in DRAIN (fetch_stall_o=0 so the newest target wins).
- Flush and delivery in the same cycle: flush wins, no inst_valid_o pulse.
- Reset mid-transaction: state is forced to REQ. A bus response arriving after reset while not in WAIT/DRAIN is ignored.
- data_ok in REQ (spurious) is ignored.

Decomposition:
- Shared package / defines.vh:
  - state encoding (IF_REQ, IF_WAIT, IF_HOLD, IF_DRAIN)
  - UNCACHED_SEG constant
  - NOP_INST constant
  - reset polarity macro for active-low
- Natural sub-module: inst_hold_buf, a one-entry skid register holding {inst, pc, adel} with load/clear/valid.
- FSM and output logic stay in inst_fetch_ctrl.

Test Plan:
- Basic fetch: reset release with pc_i=32'hbfc0_0000; addr_ok on cycle 1, data_ok with 32'h2408_0001 on cycle 3 → inst_req_o=1 and inst_uncached_o=1 on cycle 1; fetch_stall_o=0 on cycle 3 only; inst_valid_o pulses on cycle 4 with inst_o=32'h2408_0001, inst_pc_o=32'hbfc0_0000.
- Decode stall: data_ok arrives while pipe_stall_i=1 for 3 cycles → no inst_valid_o and fetch_stall_o=1 throughout; the instruction is delivered the cycle after pipe_stall_i falls.
- Flush while waiting: flush_i=1 in WAIT with data_ok 2 cycles later → enter DRAIN; returned data dropped (no inst_valid_o); next request uses the new pc_i=32'h8000_0180.
- Flush coincident with data_ok, and flush in HOLD → no inst_valid_o pulse; state returns to REQ; fetch_stall_o=0 in the flush cycle.
- Misaligned PC: pc_i=32'hbfc0_0002 → inst_req_o stays 0; next cycle inst_valid_o=1, inst_o=NOP_INST, inst_adel_o=1, inst_pc_o=32'hbfc0_0002.
- Async reset asserted in WAIT between clock edges → outputs clear immediately; after release the FSM is in REQ and a late data_ok produces no pulse.
